alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus {z,n,c,v} flags, with output backpressure.
- Adds multi-bit shifts, carry-chained ADC/SBC, CMP and an iterative shift-add multiply.
- Sits between the datapath register file and the writeback/flag register in the CPU core.

Parameters:
- WIDTH, 8, operand/result width; power of 2, at least 4.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B, or shift amount.
- op  in  4  operation code (alu_pkg).
- out_valid  out  1  result_out/flags_out/err hold a valid result.
- out_ready  in  1  consumer takes the result.
- result_out  out  WIDTH  registered result.
- flags_out  out  4  {z,n,c,v}; registered and persistent.
- err  out  1  set alongside out_valid when op was reserved.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result_out=0, flags_out=0, err=0, multiplier counter=0. An in-flight MUL is discarded; no partial result is ever presented.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A request is accepted on a rising edge with in_valid && in_ready; a, b and op are captured on that edge.
  - A result is consumed on an edge with out_valid && out_ready. out_valid drops on that edge unless a new single-cycle result loads on the same edge; in that case it stays 1 (back-to-back, 1 op/cycle).
  - result_out, flags_out and err are held stable while out_valid && !out_ready.
- Latency:
  - Single-cycle ops: accepted at edge t, out_valid=1 after edge t.
  - MUL: state=BUSY for WIDTH cycles, out_valid=1 after edge t+WIDTH; in_ready=0 throughout.
- FSM: IDLE -(accept MUL)-> BUSY; BUSY -(count==WIDTH-1)-> IDLE with the result loaded; IDLE self-loops for all other ops.
- Flags:
  - z=(result==0), n=result[WIDTH-1] for every op. Exception: CMP computes z and n from the difference.
  - c and v are 0 unless stated below.
  - flags_out updates only when a result loads; it is unchanged across idle cycles. ADC/SBC read flags_out.c as registered at acceptance time.
- Operations (op: function):
  - 0 ADD: a+b; c=carry-out; v=(a[MSB]==b[MSB])&&(r[MSB]!=a[MSB]).
  - 1 SUB: a-b; c=~borrow; v=(a[MSB]!=b[MSB])&&(r[MSB]!=a[MSB]).
  - 2 AND, 3 OR, 5 XOR: bitwise.
  - 4 NOT: ~a.
  - 6 SHL, 7 SHR (logical), 10 SAR (arithmetic), 11 ROL: shift/rotate by k=b[SHAMT_W-1:0].
    - c = last bit shifted/rotated out.
    - k=0: result=a, c=0.
  - 8 ADC: a+b+c_q, flags as ADD.
  - 9 SBC: a-b-~c_q (borrow-in = ~c_q), flags as SUB.
  - 12 CMP: flags as SUB; result_out=a.
  - 13 MUL: unsigned; result = low WIDTH bits of a*b; c = v = (high WIDTH bits != 0).
  - 14, 15 reserved: result=0, flags z=1 and others 0, err=1. err is 0 for all valid ops.
- Width rules: internal add/sub use WIDTH+1 bits; MUL accumulator is 2*WIDTH bits.

Decomposition:
- alu_pkg:
  - op-code localparams (OP_ADD..OP_MUL, OP_RSV0/1).
  - flag bit indices (F_Z=3, F_N=2, F_C=1, F_V=0).
  - FSM state encoding (IDLE, BUSY).
- Sub-module alu_mul_iter:
  - Interface: start, a, b → done pulse and 2*WIDTH product.
  - Behaviour: shift-add, one bit per cycle; async reset clears it.
- Top holds the combinational single-cycle unit, handshake/output registers and flag register.

Test Plan:
- WIDTH=8, reset then ADD a=0x7F b=0x01, out_ready=1 → after 1 edge result=0x80, flags=0101 (n,v); next cycle out_valid=0 if no new op.
- SUB a=0x00 b=0x01 → result=0xFF, flags=0100 (n=1, c=0 borrow); then SBC a=0x00 b=0x00 → result=0xFF (borrow-in = ~c_q = 1).
- ADD 0xFF+0x01 (c=1), then ADC 0x00+0x00 → 0x01 flags 0000; SHL a=0x81 k=1 → 0x02 c=1; SAR a=0x80 k=3 → 0xF0 c=0; ROL a=0x81 k=0 → 0x81 c=0.
- MUL a=0x10 b=0x10 → in_ready=0 for 8 cycles, out_valid after edge t+8, result=0x00, flags=1011 (z,c,v); MUL 3*5 → 0x0F flags 0000.
- out_ready=0 while 3 ops offered → first result held stable, in_ready=0, no op lost; release out_ready → remaining results stream at 1/cycle in order.
- op=14 → err=1, result=0, z=1; assert rst_n=0 at cycle 4 of a MUL → out_valid=0, flags=0 immediately (asynchronously); after release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag indices and FSM encoding for alu_seq
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SAR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_RSV0 = 4'd14;
    localparam logic [3:0] OP_RSV1 = 4'd15;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one bit per cycle
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  w_acc_next;
    logic                w_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // done and product are presented during the final iteration so the
    // consumer can register the finished product on the same edge.
    assign done    = r_busy && w_last;
    assign product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake, flag register and iterative MUL
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result_out,
    output logic [3:0]        flags_out,
    output logic              err
);

    localparam int MSB = WIDTH - 1;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_result;
    logic [3:0]          r_flags;
    logic                r_err;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_mul_start;
    logic                w_load;
    logic                w_load_mul;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_mul_product;

    logic [SHAMT_W-1:0]  w_k;
    logic [SHAMT_W-1:0]  w_k_neg;
    logic                w_cin;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH:0]      w_shl;
    logic [WIDTH:0]      w_shr;
    logic [WIDTH:0]      w_sar;
    logic [WIDTH-1:0]    w_rol;
    logic [WIDTH-1:0]    w_res;
    logic [WIDTH-1:0]    w_zn;
    logic                w_c;
    logic                w_v;
    logic                w_err;
    logic [3:0]          w_flags_alu;
    logic [WIDTH-1:0]    w_mul_res;
    logic [3:0]          w_flags_mul;

    assign w_k     = b[SHAMT_W-1:0];
    assign w_k_neg = -w_k;
    assign w_cin   = r_flags[F_C];

    // The extra bit on each shift operand catches the last bit shifted out.
    assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & w_cin};
    assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & ~w_cin};
    assign w_shl  = {1'b0, a} << w_k;
    assign w_shr  = {a, 1'b0} >> w_k;
    assign w_sar  = $signed({a, 1'b0}) >>> w_k;
    assign w_rol  = (a << w_k) | (a >> w_k_neg);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                w_res = (op == OP_CMP) ? a : w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_SAR: begin
                w_res = w_sar[WIDTH:1];
                w_c   = w_sar[0];
            end
            OP_ROL: begin
                w_res = w_rol;
                w_c   = (w_k != '0) && w_rol[0];
            end
            OP_RSV0, OP_RSV1: w_err = 1'b1;
            default: w_res = '0;
        endcase
    end

    // CMP keeps a as its result but reports z/n of the difference.
    assign w_zn = (op == OP_CMP) ? w_diff[WIDTH-1:0] : w_res;

    always_comb begin
        w_flags_alu      = '0;
        w_flags_alu[F_Z] = (w_zn == '0);
        w_flags_alu[F_N] = w_zn[MSB];
        w_flags_alu[F_C] = w_c;
        w_flags_alu[F_V] = w_v;
    end

    assign w_mul_res = w_mul_product[WIDTH-1:0];

    always_comb begin
        w_flags_mul      = '0;
        w_flags_mul[F_Z] = (w_mul_res == '0);
        w_flags_mul[F_N] = w_mul_res[MSB];
        w_flags_mul[F_C] = (w_mul_product[2*WIDTH-1:WIDTH] != '0);
        w_flags_mul[F_V] = (w_mul_product[2*WIDTH-1:WIDTH] != '0);
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_mul_start  = 1'b0;
        w_load       = 1'b0;
        w_load_mul   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = !r_out_valid || out_ready;
                w_accept   = in_valid && w_in_ready;
                if (w_accept && (op == OP_MUL)) begin
                    w_mul_start  = 1'b1;
                    w_state_next = BUSY;
                end else if (w_accept) begin
                    w_load = 1'b1;
                end
            end
            BUSY: begin
                if (w_mul_done) begin
                    w_load       = 1'b1;
                    w_load_mul   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_load_mul ? w_mul_res : w_res;
            r_flags     <= w_load_mul ? w_flags_mul : w_flags_alu;
            r_err       <= w_load_mul ? 1'b0 : w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign result_out = r_result;
    assign flags_out  = r_flags;
    assign err        = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed and randomized operations
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   f;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result_out;
    logic [3:0]   flags_out;
    logic         err;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   model_c = 0;
    bit   bp_en = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .flags_out  (flags_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int r, input int f, input int e);
        exp_t x;
        x.r = W'(r);
        x.f = 4'(f);
        x.e = 1'(e);
        return x;
    endfunction

    function automatic int sgn(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Reference computed from integer arithmetic on the operand values.
    function automatic exp_t ref_model(input int o, input int av, input int bv, input int cin);
        int mask = (1 << W) - 1;
        int k = bv % W;
        int sa = sgn(av);
        int sb = sgn(bv);
        int maxs = (1 << (W - 1)) - 1;
        int mins = -(1 << (W - 1));
        int r = 0;
        int zn;
        int c = 0;
        int v = 0;
        int e = 0;
        int t;
        case (o)
            0, 8: begin
                t = av + bv + ((o == 8) ? cin : 0);
                r = t & mask;
                c = (t > mask) ? 1 : 0;
                t = sa + sb + ((o == 8) ? cin : 0);
                v = (t > maxs || t < mins) ? 1 : 0;
            end
            1, 9, 12: begin
                t = av - bv - ((o == 9) ? (1 - cin) : 0);
                r = t & mask;
                c = (t >= 0) ? 1 : 0;
                t = sa - sb - ((o == 9) ? (1 - cin) : 0);
                v = (t > maxs || t < mins) ? 1 : 0;
            end
            2: r = av & bv;
            3: r = av | bv;
            4: r = (~av) & mask;
            5: r = av ^ bv;
            6: begin
                r = (av << k) & mask;
                c = (k != 0) ? ((av >> (W - k)) & 1) : 0;
            end
            7: begin
                r = av >> k;
                c = (k != 0) ? ((av >> (k - 1)) & 1) : 0;
            end
            10: begin
                r = (sa >>> k) & mask;
                c = (k != 0) ? ((sa >>> (k - 1)) & 1) : 0;
            end
            11: begin
                r = (k != 0) ? (((av << k) | (av >> (W - k))) & mask) : av;
                c = (k != 0) ? (r & 1) : 0;
            end
            13: begin
                t = av * bv;
                r = t & mask;
                c = ((t >> W) != 0) ? 1 : 0;
                v = c;
            end
            default: e = 1;
        endcase
        zn = r;
        if (o == 12) r = av;
        return mk(r, (((zn == 0) ? 1 : 0) << 3) | (((zn >> (W - 1)) & 1) << 2) | (c << 1) | v, e);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got result 0x%0h with no result required", result_out);
            end else begin
                check("result", result_out, sb_q[0].r);
                check("flags", flags_out, sb_q[0].f);
                check("err", err, sb_q[0].e);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e);
        int n = 0;
        op = o;
        a = av;
        b = bv;
        in_valid = 1'b1;
        forever begin
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        sb_q.push_back(e);
        model_c = int'(e.f[F_C]);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        issue(o, av, bv, ref_model(int'(o), int'(av), int'(bv), model_c));
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sb_q.size(), 0);
    endtask

    task automatic mul_latency();
        int n = 0;
        while (!out_valid && n < 40) begin
            check("mul_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_latency", n, W);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result_out, 0);
        check("rst_flags", flags_out, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_ADD, 8'h7F, 8'h01, mk('h80, 'b0101, 0));
        check("add_latency_valid", out_valid, 1);
        @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);

        issue(OP_SUB, 8'h00, 8'h01, mk('hFF, 'b0100, 0));
        issue(OP_SBC, 8'h00, 8'h00, mk('hFF, 'b0100, 0));
        issue(OP_ADD, 8'hFF, 8'h01, mk('h00, 'b1010, 0));
        issue(OP_ADC, 8'h00, 8'h00, mk('h01, 'b0000, 0));
        issue(OP_SHL, 8'h81, 8'h01, mk('h02, 'b0010, 0));
        issue(OP_SAR, 8'h80, 8'h03, mk('hF0, 'b0100, 0));
        issue(OP_ROL, 8'h81, 8'h00, mk('h81, 'b0100, 0));
        issue(OP_CMP, 8'h05, 8'h07, mk('h05, 'b0100, 0));
        issue(OP_SHR, 8'h81, 8'h01, mk('h40, 'b0010, 0));
        drain();

        issue(OP_MUL, 8'h10, 8'h10, mk('h00, 'b1011, 0));
        mul_latency();
        issue(OP_MUL, 8'h03, 8'h05, mk('h0F, 'b0000, 0));
        mul_latency();
        issue(OP_RSV0, 8'h12, 8'h34, mk('h00, 'b1000, 1));
        drain();

        out_ready = 1'b0;
        fork
            begin
                issue_model(OP_ADD, 8'($urandom), 8'($urandom));
                issue_model(OP_XOR, 8'($urandom), 8'($urandom));
                issue_model(OP_SUB, 8'($urandom), 8'($urandom));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_in_ready", in_ready, 0);
                check("bp_held_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        drain();

        issue(OP_ADD, 8'hFF, 8'hFF, mk('hFE, 'b0110, 0));
        issue(OP_MUL, 8'h03, 8'h05, mk('h0F, 'b0000, 0));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_flags", flags_out, 0);
        check("async_rst_result", result_out, 0);
        sb_q.delete();
        model_c = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("discarded_mul_valid", out_valid, 0);
        issue(OP_ADD, 8'h01, 8'h02, mk('h03, 'b0000, 0));
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
            issue_model(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end
        bp_en = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
